seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Downstream consumer of a game stage's packed 20-bit display word: four 5-bit digit codes.
//  Latches the word once per frame, time-multiplexes four common 7-segment digits, and decodes
//  codes to segments, with anti-ghost blanking per slot. An optional flash input blinks the
//  whole display, e.g. driven by a game's victory flag. Sits between game muxing and FPGA pins.
// PARAMETERS
//  SCAN_DIV      16'd50000  clk cycles per digit slot (>=2); 1 ms/digit at 50 MHz
//  BLANK_CYC     16'd500    cycles at slot start with all digit enables off (< SCAN_DIV)
//  BLINK_FRAMES  8'd125     frames per flash half-period (>=1)
//  SEG_ACT_LOW   1'b1       1: segments active-low; 0: active-high
//  EN_ACT_LOW    1'b0       1: digit enables active-low; 0: active-high
// PORTS
//  clk        in   1   system clock
//  reset_n    in   1   asynchronous active-low reset
//  bits       in   20  digit codes: [19:15]=leftmost digit ... [4:0]=rightmost digit
//  flash      in   1   1 = blink display at BLINK_FRAMES rate
//  leds       out  8   segments {dp,g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW; dp always inactive
//  ct         out  4   digit enables, ct[3]=leftmost, polarity per EN_ACT_LOW
//  frame_tick out  1   1-cycle pulse when a new frame snapshot of bits is taken
// BEHAVIOUR
//  Code map (5-bit): 0x00-0x0F hex 0-F; 0x10 dash (g only); 0x1F and 0x11-0x1E blank.
//  Prescaler pre counts 0..SCAN_DIV-1, then wraps. Slot index slot advances by 1 on wrap (mod 4).
//  Slot k shows digit k (k=0 leftmost, code bits[19-5k -: 5]) and enables ct[3-k].
//  Snapshot: on the cycle pre wraps with slot==3, or the first cycle after reset release,
//   snap<=bits and frame_tick=1. Displayed data comes only from snap; mid-frame bits changes
//   are invisible until the next frame.
//  Blanking: while pre < BLANK_CYC, all ct inactive; leds still show the slot's decode.
//  Flash: frame counter fcnt counts snapshots 0..BLINK_FRAMES-1 and wraps. On each wrap, phase
//   toggles while flash=1. While flash=1 and phase=0, ct stays inactive. When flash=0,
//   phase<=1 and fcnt<=0 at the next cycle, so the display returns within one cycle.
//   Rising flash starts with a visible half-period.
//  Outputs are registered: leds/ct reflect pre/slot/snap/phase of the previous cycle
//   (1-cycle latency). Exactly one ct bit is active, or none.
//  Reset (async assert, sync-released state): pre=0, slot=0, snap=20'hFFFFF (all blank),
//   fcnt=0, phase=1, leds all inactive, ct all inactive, frame_tick=0.
//  Reset mid-scan: outputs go inactive immediately, with no glitch to an active ct.
//   Scan restarts at slot 0 with a fresh snapshot.
//  Counter widths: pre 16 b, fcnt 8 b, slot 2 b. Wraps are explicit compares, not overflow.
// TESTING (SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2, SEG_ACT_LOW=1, EN_ACT_LOW=0)
//  1 Hold reset_n=0 -> leds=8'hFF, ct=4'b0000, frame_tick=0; release -> frame_tick one cycle.
//  2 bits=20'b00000_10000_10000_11111 -> per slot, after 1 blank cycle:
//    ct=1000 leds=8'hC0 ('0'); ct=0100 leds=8'hBF ('-'); ct=0010 leds=8'hBF; ct=0001 leds=8'hFF.
//  3 Change bits to digit0=0x07 during slot 1 -> slots 1-3 unchanged;
//    next frame slot 0 shows leds=8'hF8 ('7').
//  4 Sweep digit0 codes 0x00-0x1F -> leds match hex table; 0x10=8'hBF;
//    0x11-0x1F=8'hFF; dp bit always 1.
//  5 flash=1 for 8 frames -> ct active 2 frames, dark 2 frames, repeating;
//    drop flash while dark -> ct active by the next slot.
//  6 Assert reset_n=0 asynchronously mid-slot 2 -> ct=0000 same cycle (no clk edge needed);
//    release -> scan resumes at slot 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Brief    : Latches a packed 20-bit word of four 5-bit digit codes once per
//            frame, then time-multiplexes four 7-segment digits. Each slot
//            starts with a few cycles of anti-ghost blanking. An optional
//            flash input blinks the whole display at a frame-based rate.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
   parameter logic [15:0] SCAN_DIV     = 16'd50000,
   parameter logic [15:0] BLANK_CYC    = 16'd500,
   parameter logic [7:0]  BLINK_FRAMES = 8'd125,
   parameter logic        SEG_ACT_LOW  = 1'b1,
   parameter logic        EN_ACT_LOW   = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [19:0] bits,
   input  logic        flash,
   output logic [7:0]  leds,
   output logic [3:0]  ct,
   output logic        frame_tick
);

   // Idle levels of the pins for the chosen polarities
   localparam logic [7:0] c_LEDS_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
   localparam logic [3:0] c_CT_OFF   = EN_ACT_LOW  ? 4'hF  : 4'h0;

   logic [15:0] r_pre;
   logic [1:0]  r_slot;
   logic [19:0] r_snap;
   logic [7:0]  r_fcnt;
   logic        r_phase;
   logic        r_first;
   logic [7:0]  r_leds;
   logic [3:0]  r_ct;
   logic        r_frame_tick;

   logic        w_pre_wrap;
   logic        w_snap_now;
   logic [4:0]  w_code;
   logic [7:0]  w_seg;
   logic [3:0]  w_onehot;
   logic        w_dark;

   assign w_pre_wrap = (r_pre == (SCAN_DIV - 16'd1));
   // A new frame begins when the last slot finishes, or right after reset
   assign w_snap_now = r_first | (w_pre_wrap & (r_slot == 2'd3));
   // Digits go dark during the slot's blanking window or the flash off-phase
   assign w_dark     = (r_pre < BLANK_CYC) | (flash & ~r_phase);

   // Select the current slot's code and its digit enable (slot 0 = leftmost)
   always_comb begin
      w_code   = r_snap[19:15];
      w_onehot = 4'b1000;
      case (r_slot)
         2'd0: begin w_code = r_snap[19:15]; w_onehot = 4'b1000; end
         2'd1: begin w_code = r_snap[14:10]; w_onehot = 4'b0100; end
         2'd2: begin w_code = r_snap[9:5];   w_onehot = 4'b0010; end
         default: begin w_code = r_snap[4:0]; w_onehot = 4'b0001; end
      endcase
   end

   // Code to segment pattern, active-high {dp,g,f,e,d,c,b,a}; dp never lit
   always_comb begin
      w_seg = 8'h00;
      case (w_code)
         5'h00: w_seg = 8'h3F;
         5'h01: w_seg = 8'h06;
         5'h02: w_seg = 8'h5B;
         5'h03: w_seg = 8'h4F;
         5'h04: w_seg = 8'h66;
         5'h05: w_seg = 8'h6D;
         5'h06: w_seg = 8'h7D;
         5'h07: w_seg = 8'h07;
         5'h08: w_seg = 8'h7F;
         5'h09: w_seg = 8'h6F;
         5'h0A: w_seg = 8'h77;
         5'h0B: w_seg = 8'h7C;
         5'h0C: w_seg = 8'h39;
         5'h0D: w_seg = 8'h5E;
         5'h0E: w_seg = 8'h79;
         5'h0F: w_seg = 8'h71;
         5'h10: w_seg = 8'h40;
         default: w_seg = 8'h00;
      endcase
   end

   // Slot prescaler and slot index; both wrap by explicit compare
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pre  <= 16'd0;
         r_slot <= 2'd0;
      end else if (w_pre_wrap) begin
         r_pre  <= 16'd0;
         r_slot <= (r_slot == 2'd3) ? 2'd0 : r_slot + 2'd1;
      end else begin
         r_pre  <= r_pre + 16'd1;
      end
   end

   // Frame snapshot of the input word; first-cycle flag forces one after reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_snap  <= 20'hFFFFF;
         r_first <= 1'b1;
      end else begin
         r_first <= 1'b0;
         if (w_snap_now) begin
            r_snap <= bits;
         end
      end
   end

   // Flash phase: toggles every BLINK_FRAMES snapshots; held visible when idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fcnt  <= 8'd0;
         r_phase <= 1'b1;
      end else if (!flash) begin
         r_fcnt  <= 8'd0;
         r_phase <= 1'b1;
      end else if (w_snap_now) begin
         if (r_fcnt == (BLINK_FRAMES - 8'd1)) begin
            r_fcnt  <= 8'd0;
            r_phase <= ~r_phase;
         end else begin
            r_fcnt  <= r_fcnt + 8'd1;
         end
      end
   end

   // Registered pin drivers; reset forces them idle without waiting for clk
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_leds       <= c_LEDS_OFF;
         r_ct         <= c_CT_OFF;
         r_frame_tick <= 1'b0;
      end else begin
         r_leds       <= SEG_ACT_LOW ? ~w_seg : w_seg;
         r_ct         <= w_dark ? c_CT_OFF : (EN_ACT_LOW ? ~w_onehot : w_onehot);
         r_frame_tick <= w_snap_now;
      end
   end

   assign leds       = r_leds;
   assign ct         = r_ct;
   assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Brief    : Directed self-checking bench for seg7_scan_driver with a short
//            scan (4 cycles/slot, 1 blank cycle, 2-frame blink half-period).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

   localparam logic [19:0] c_W1 = {5'h00, 5'h10, 5'h10, 5'h1F};
   localparam logic [19:0] c_W2 = {5'h07, 5'h10, 5'h10, 5'h1F};

   logic        clk = 1'b0;
   logic        reset_n;
   logic [19:0] bits;
   logic        flash;
   logic [7:0]  leds;
   logic [3:0]  ct;
   logic        frame_tick;

   int errors = 0;
   int checks = 0;

   seg7_scan_driver #(
      .SCAN_DIV     (16'd4),
      .BLANK_CYC    (16'd1),
      .BLINK_FRAMES (8'd2),
      .SEG_ACT_LOW  (1'b1),
      .EN_ACT_LOW   (1'b0)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bits       (bits),
      .flash      (flash),
      .leds       (leds),
      .ct         (ct),
      .frame_tick (frame_tick)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Expected active-low segment byte for a code (hand-written table)
   function automatic logic [7:0] exp_seg(input logic [4:0] c);
      logic [7:0] v;
      case (c)
         5'h00: v = 8'hC0;  5'h01: v = 8'hF9;  5'h02: v = 8'hA4;  5'h03: v = 8'hB0;
         5'h04: v = 8'h99;  5'h05: v = 8'h92;  5'h06: v = 8'h82;  5'h07: v = 8'hF8;
         5'h08: v = 8'h80;  5'h09: v = 8'h90;  5'h0A: v = 8'h88;  5'h0B: v = 8'h83;
         5'h0C: v = 8'hC6;  5'h0D: v = 8'hA1;  5'h0E: v = 8'h86;  5'h0F: v = 8'h8E;
         5'h10: v = 8'hBF;
         default: v = 8'hFF;
      endcase
      return v;
   endfunction

   // Code shown in slot s (0 = leftmost) for a packed word
   function automatic logic [4:0] digit(input logic [19:0] w, input int s);
      logic [4:0] d;
      case (s)
         0: d = w[19:15];
         1: d = w[14:10];
         2: d = w[9:5];
         default: d = w[4:0];
      endcase
      return d;
   endfunction

   function automatic logic [19:0] sweep_word(input int c);
      logic [4:0] c5;
      c5 = c[4:0];
      return {c5, 5'h10, 5'h10, 5'h1F};
   endfunction

   task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Walk frame steps first..last (step = slot*4 + pre of the displayed state).
   // Digits are enabled from step vis_from on; at step chg_at bits/flash change.
   task automatic run_frame(input int first, input int last, input logic [19:0] word,
                            input int vis_from, input int chg_at,
                            input logic [19:0] chg_bits, input logic chg_flash);
      int         s;
      int         p;
      logic [3:0] e_ct;
      for (int i = first; i <= last; i++) begin
         @(negedge clk);
         s = i / 4;
         p = i % 4;
         e_ct = (p == 0 || i < vis_from) ? 4'b0000 : (4'b1000 >> s);
         chk($sformatf("leds step%0d word%h", i, word), 20'(leds), 20'(exp_seg(digit(word, s))));
         chk($sformatf("ct step%0d word%h", i, word), 20'(ct), 20'(e_ct));
         chk($sformatf("frame_tick step%0d", i), 20'(frame_tick), 20'(i == 15));
         if (i == chg_at) begin
            bits  = chg_bits;
            flash = chg_flash;
         end
      end
   endtask

   int vis_pat [10] = '{0, 0, 16, 16, 0, 0, 16, 16, 0, 0};

   initial begin
      reset_n = 1'b0;
      flash   = 1'b0;
      bits    = c_W1;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset leds", 20'(leds), 20'h000FF);
      chk("reset ct", 20'(ct), 20'h00000);
      chk("reset frame_tick", 20'(frame_tick), 20'h00000);

      // Release: first edge snapshots, display still blank
      reset_n = 1'b1;
      @(negedge clk);
      chk("release frame_tick", 20'(frame_tick), 20'h00001);
      chk("release ct", 20'(ct), 20'h00000);
      chk("release leds", 20'(leds), 20'h000FF);

      // Basic scan of '0' '-' '-' blank
      run_frame(1, 15, c_W1, 0, -1, c_W1, 1'b0);

      // Mid-frame change of digit 0 is invisible until next frame
      run_frame(0, 15, c_W1, 0, 5, c_W2, 1'b0);
      run_frame(0, 15, c_W2, 0, 14, sweep_word(0), 1'b0);

      // Sweep every code through digit 0
      for (int c = 0; c < 32; c++) begin
         run_frame(0, 15, sweep_word(c), 0, 14, (c == 31) ? c_W1 : sweep_word(c + 1), 1'b0);
      end

      // Flash: visible 2 frames, dark 2 frames, repeating
      flash = 1'b1;
      for (int f = 0; f < 10; f++) begin
         run_frame(0, 15, c_W1, vis_pat[f], -1, c_W1, 1'b1);
      end
      // Dark frame: drop flash at slot 1 start, digits return on the next cycle
      run_frame(0, 15, c_W1, 5, 4, c_W1, 1'b0);
      run_frame(0, 15, c_W1, 0, -1, c_W1, 1'b0);

      // Async reset mid-slot 2, between clock edges
      run_frame(0, 9, c_W1, 0, -1, c_W1, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async reset ct", 20'(ct), 20'h00000);
      chk("async reset leds", 20'(leds), 20'h000FF);
      chk("async reset frame_tick", 20'(frame_tick), 20'h00000);
      bits = c_W2;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("re-release frame_tick", 20'(frame_tick), 20'h00001);
      chk("re-release ct", 20'(ct), 20'h00000);
      run_frame(1, 15, c_W2, 0, -1, c_W2, 1'b0);
      run_frame(0, 15, c_W2, 0, -1, c_W2, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
